// File: rtl/mips_avalon_pkg.sv
// Shared types and constants for the Avalon-MM memory responder.
package mips_avalon_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_WAIT = 2'd1,
        STATE_DONE = 2'd2
    } resp_state_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/avalon_mem_bram.sv
// Single-port synchronous RAM with per-byte write enables and a registered read.
module avalon_mem_bram
    import mips_avalon_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic                 we_i,
    input  logic [3:0]           be_i,
    input  logic [31:0]          wdata_i,
    input  logic                 rd_en_i,
    input  logic                 rd_clr_i,
    output logic [31:0]          rdata_o
);

    logic [31:0] mem_q [2**ADDR_BITS];
    logic [31:0] rdata_q;

    // Contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // Clear takes priority so an out-of-range read returns zero.
    always_ff @(posedge clk_i) begin
        if (rst_i || rd_clr_i) rdata_q <= '0;
        else if (rd_en_i)      rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM responder: decodes the bus, stalls WAIT_CYCLES cycles, then serves the RAM.
module avalon_mem_responder
    import mips_avalon_pkg::*;
#(
    parameter int          ADDR_BITS   = 10,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        protocol_err,
    output logic        busy
);

    // Handshake: a transfer completes on the rising edge where read or write is
    // held and waitrequest is low; the initiator must hold its request until then.
    localparam logic [31:0] SPAN = 32'(WORD_BYTES) << ADDR_BITS;

    resp_state_t state_q, state_d;
    logic [3:0]  counter_q, counter_d;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic        wr_q;
    logic        err_q, err_d;

    logic        req, is_idle, latch_en, op_wr, enter_done;
    logic [31:0] cur_addr, offset;
    logic        in_range;
    logic [ADDR_BITS-1:0] word_idx;
    logic        ram_we, ram_rd_en, ram_rd_clr;

    assign req      = read | write;
    assign is_idle  = (state_q == STATE_IDLE);
    assign latch_en = is_idle & req;

    // Live bus is decoded in IDLE (WAIT_CYCLES==1 reads on the latch edge).
    assign cur_addr = is_idle ? address : addr_q;
    assign op_wr    = is_idle ? write : wr_q;
    assign offset   = {cur_addr[31:2], 2'b00} - BASE_ADDR;
    assign in_range = (offset < SPAN);
    assign word_idx = offset[ADDR_BITS+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= STATE_IDLE;
            counter_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
        end else if (latch_en) begin
            addr_q  <= address;
            wdata_q <= writedata;
            be_q    <= byteenable;
            wr_q    <= write;
        end
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        unique case (state_q)
            STATE_IDLE: if (req) begin
                counter_d = 4'(WAIT_CYCLES - 1);
                state_d   = (WAIT_CYCLES == 1) ? STATE_DONE : STATE_WAIT;
            end
            STATE_WAIT: begin
                counter_d = counter_q - 4'd1;
                if (counter_q == 4'd1) state_d = STATE_DONE;
            end
            STATE_DONE: state_d = STATE_IDLE;
            default:    state_d = STATE_IDLE;
        endcase
    end

    // Sticky error: illegal request shape at latch, or the bus moved while stalled.
    always_comb begin
        err_d = err_q;
        if (latch_en && ((read && write) || (address[1:0] != 2'b00) ||
                         (write && byteenable == 4'h0)))
            err_d = 1'b1;
        if (state_q == STATE_WAIT &&
            (!(wr_q ? write : read) || (address != addr_q)))
            err_d = 1'b1;
    end

    always_comb begin
        waitrequest = 1'b0;
        busy        = 1'b0;
        unique case (state_q)
            STATE_IDLE: waitrequest = req;
            STATE_WAIT: begin waitrequest = 1'b1; busy = 1'b1; end
            STATE_DONE: busy = 1'b1;
            default:    waitrequest = 1'b0;
        endcase
    end

    assign enter_done = (state_d == STATE_DONE) && (state_q != STATE_DONE);
    assign ram_we     = !rst && (state_q == STATE_DONE) && wr_q && in_range;
    assign ram_rd_en  = !rst && enter_done && !op_wr && in_range;
    assign ram_rd_clr = !rst && enter_done && !op_wr && !in_range;

    avalon_mem_bram #(.ADDR_BITS(ADDR_BITS)) u_bram (
        .clk_i    (clk),
        .rst_i    (rst),
        .addr_i   (word_idx),
        .we_i     (ram_we),
        .be_i     (be_q),
        .wdata_i  (wdata_q),
        .rd_en_i  (ram_rd_en),
        .rd_clr_i (ram_rd_clr),
        .rdata_o  (readdata)
    );

    assign protocol_err = err_q;

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Directed bench for avalon_mem_responder: drivers push expected read data, a monitor checks it.
module tb_avalon_mem_responder;

    localparam int WAITS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        protocol_err;
    logic        busy;

    logic [31:0] exp_q[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          done_cyc;
    int          prev_cyc;

    avalon_mem_responder #(
        .ADDR_BITS   (10),
        .BASE_ADDR   (32'hBFC00000),
        .WAIT_CYCLES (WAITS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .address      (address),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .byteenable   (byteenable),
        .waitrequest  (waitrequest),
        .readdata     (readdata),
        .protocol_err (protocol_err),
        .busy         (busy)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completed read is checked against the expected queue
    always @(negedge clk) begin
        if (!rst && read && !write && !waitrequest) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: got %h expected no read", readdata);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (readdata !== e) begin
                    n_fail++;
                    $display("FAIL rd_data @%h: got %h expected %h", address, readdata, e);
                end
            end
        end
    end

    // Driver: runs one transfer, checks stall count; hold keeps the request up
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input bit hold);
        int  waits;
        bit  done;
        address = a; write = wr; read = !wr; writedata = d; byteenable = be;
        waits = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (waitrequest) waits++;
            else begin done = 1; done_cyc = cyc; end
            @(posedge clk); #1;
        end
        if (!done) begin
            n_vec++; n_fail++;
            $display("FAIL timeout @%h: got no completion expected one", a);
        end else begin
            check("wait_cycles", 32'(waits), 32'(WAITS));
        end
        if (!hold) begin read = 1'b0; write = 1'b0; end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] e, input bit hold);
        exp_q.push_back(e);
        xfer(1'b0, a, 32'h0, 4'h0, hold);
    endtask

    initial begin
        rst = 1'b1; address = '0; read = 1'b0; write = 1'b0;
        writedata = '0; byteenable = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_waitrequest", 32'(waitrequest), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(protocol_err), 32'd0);
        check("rst_readdata", readdata, 32'h0);
        @(posedge clk); #1;

        // Write then read back
        xfer(1'b1, 32'hBFC00010, 32'hDEADBEEF, 4'hF, 0);
        do_read(32'hBFC00010, 32'hDEADBEEF, 0);
        check("err_after_rw", 32'(protocol_err), 32'd0);

        // Byte merge
        xfer(1'b1, 32'hBFC00020, 32'h11223344, 4'hF, 0);
        xfer(1'b1, 32'hBFC00020, 32'hAABBCCDD, 4'b0101, 0);
        do_read(32'hBFC00020, 32'h11BB33DD, 0);

        // Back-to-back writes, request held throughout
        xfer(1'b1, 32'hBFC00040, 32'h00000A01, 4'hF, 1);
        prev_cyc = done_cyc;
        xfer(1'b1, 32'hBFC00044, 32'h00000B02, 4'hF, 1);
        check("b2b_gap1", 32'(done_cyc - prev_cyc), 32'(WAITS + 1));
        prev_cyc = done_cyc;
        xfer(1'b1, 32'hBFC00048, 32'h00000C03, 4'hF, 0);
        check("b2b_gap2", 32'(done_cyc - prev_cyc), 32'(WAITS + 1));
        do_read(32'hBFC00040, 32'h00000A01, 1);
        do_read(32'hBFC00044, 32'h00000B02, 1);
        do_read(32'hBFC00048, 32'h00000C03, 0);
        check("err_after_b2b", 32'(protocol_err), 32'd0);

        // Out-of-range write/read leave word 0 untouched
        xfer(1'b1, 32'hBFC00000, 32'h01020304, 4'hF, 0);
        xfer(1'b1, 32'h00000000, 32'hFFFFFFFF, 4'hF, 0);
        do_read(32'h00000000, 32'h00000000, 0);
        check("err_after_oor", 32'(protocol_err), 32'd0);

        // Misaligned read returns word 0 and flags an error
        do_read(32'hBFC00002, 32'h01020304, 0);
        check("err_misaligned", 32'(protocol_err), 32'd1);

        // Reset during the stall of a write aborts it
        address = 32'hBFC00010; writedata = 32'hCAFEF00D; byteenable = 4'hF;
        write = 1'b1; read = 1'b0;
        @(negedge clk);
        check("abort_idle_wait", 32'(waitrequest), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd1);
        rst = 1'b1; write = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_wait", 32'(waitrequest), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_err", 32'(protocol_err), 32'd0);
        @(posedge clk); #1;
        do_read(32'hBFC00010, 32'hDEADBEEF, 0);
        check("err_final", 32'(protocol_err), 32'd0);

        repeat (2) @(posedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/avalon_mem_responder.md
Name: avalon_mem_responder

Overview:
- Avalon-MM responder (slave) modelling a word-addressed, byte-enabled memory.
- Sits on the far end of the bus that the CPU data cache and write buffer drive.
- Inserts a programmable number of waitrequest stall cycles per transaction, so the initiator-side handshake (waitrequest tracking, pointer advance, read-miss hijack) can be exercised in simulation and on FPGA.

Parameters:
- ADDR_BITS, 10: word-address width; memory depth 2**ADDR_BITS words.
- BASE_ADDR, 32'hBFC00000: byte address of word 0; must be word-aligned.
- WAIT_CYCLES, 2: waitrequest-high cycles per transaction; legal range 1..15.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- address  input  32  byte address from initiator
- read  input  1  read request
- write  input  1  write request
- writedata  input  32  write data
- byteenable  input  4  byte lanes for the write; bit i enables bits 8i+7:8i
- waitrequest  output  1  stall; transaction completes on the rising edge where this is low and a request is held
- readdata  output  32  read data; valid while waitrequest is low in the completion cycle
- protocol_err  output  1  sticky error flag, cleared only by rst
- busy  output  1  high in STATE_WAIT and STATE_DONE (debug)

Behaviour:
- Reset is synchronous and active-high on clk. Reset values:
  - state = STATE_IDLE
  - counter = 0
  - readdata = 0
  - protocol_err = 0
  - busy = 0
  - memory contents are not cleared
- waitrequest is combinational:
  - high in STATE_IDLE when read or write is asserted
  - high in STATE_WAIT
  - low in STATE_DONE
  - low in STATE_IDLE with no request
- STATE_IDLE:
  - Transition condition: (read|write) asserted at the edge.
  - On that edge, latch address, writedata, byteenable and the operation into holding registers.
  - Load counter = WAIT_CYCLES-1.
  - If WAIT_CYCLES==1, go to STATE_DONE; otherwise go to STATE_WAIT.
- STATE_WAIT:
  - Decrement counter each cycle; go to STATE_DONE when counter==1.
  - Total waitrequest-high cycles, counting the IDLE request cycle, equal WAIT_CYCLES.
- STATE_DONE:
  - Lasts one cycle with waitrequest low.
  - Write: at the closing edge, commit only the bytes whose byteenable bit is set; unset bytes keep their old value.
  - Read: readdata is registered on entry to DONE from the latched word address and holds until the next read completes.
  - Next state is always STATE_IDLE.
- Back-to-back requests:
  - A request held into the cycle after DONE starts a new transaction immediately; there is no dead cycle.
  - Per transaction, request-to-completion latency is WAIT_CYCLES+1 cycles.
- Address decode:
  - word index = (address - BASE_ADDR) >> 2
  - in range iff BASE_ADDR <= address < BASE_ADDR + 4*2**ADDR_BITS
  - Out-of-range write: dropped. Out-of-range read: returns 0.
  - Both still complete the handshake normally.
- protocol_err is set (sticky) by any of:
  - read and write both high in IDLE; the transaction is executed as a write.
  - address[1:0] != 0 at latch; the access proceeds using address[31:2].
  - the request drops, or address changes, during STATE_WAIT; the latched values are used and the transaction still completes.
  - byteenable == 0 on a write; this completes as a no-op.
- Reset mid-transaction:
  - Abort immediately; no memory update occurs.
  - The next cycle is IDLE with waitrequest following the request.
- Read-after-write to the same word:
  - A read whose DONE follows a write's DONE returns the merged new data.
  - No forwarding is needed because the write commits before the read latches.

Decomposition:
- Shared package mips_avalon_pkg holds:
  - typedef enum logic[1:0] resp_state_t: STATE_IDLE=0, STATE_WAIT=1, STATE_DONE=2
  - localparam WORD_BYTES=4
- Sub-module avalon_mem_bram: single-port synchronous RAM with 4 byte-lane write enables and a registered read. It is instantiated once; decode and handshake stay in the top-level module.

Test Plan:
- Write then read, WAIT_CYCLES=2, BASE_ADDR=32'hBFC00000:
  - Write 32'hDEADBEEF to 32'hBFC00010, be=4'hF, then read the same address.
  - Required: waitrequest high exactly 2 cycles per transaction; readdata=32'hDEADBEEF in the read's DONE cycle; protocol_err=0.
- Byte merge:
  - Preload 32'h11223344, write 32'hAABBCCDD with be=4'b0101, then read back.
  - Required: readdata=32'h11BB33DD.
- Back-to-back writes:
  - Hold write high for 3 transactions at consecutive addresses.
  - Required: completion edges every 3 cycles, no idle gap, all 3 words correct on readback.
- Out-of-range and misaligned accesses:
  - Write to 32'h00000000, then read it: readdata=0, handshake completes, memory unchanged.
  - Read 32'hBFC00002: returns word 0 and protocol_err=1.
- Reset mid-write:
  - Assert rst for 1 cycle during STATE_WAIT of a write of 32'hCAFEF00D.
  - Required: waitrequest low with no request after reset; readback shows the old value; protocol_err=0.
